seq_shift_add_multiplier: RTL
=============================

Name: seq_shift_add_multiplier

Overview:
- Parametrised sequential N-bit multiplier that replaces the combinational array of AND/full-adder cells with one iterative shift-add datapath.
- Processes one multiplier bit per clock and supports unsigned and two's-complement signed operands.
- Uses a start/busy/done handshake and sits between the operand source and the result consumer.
- Trades latency (WIDTH+2 cycles) for area linear in WIDTH.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request; sampled only in IDLE.
- signedMode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- inputM  input  WIDTH  multiplicand; sampled with start.
- inputQ  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  result register; holds the last completed value.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers 0. Reset mid-operation aborts with no done pulse and product=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge k latches the operands and signedMode.
  - In signed mode, each operand is replaced by its magnitude and negFlag = sign(M) XOR sign(Q). In unsigned mode, negFlag=0.
  - On the same edge: acc=0, bitCount=0, state->RUN.
- RUN, one iteration per edge for edges k+1..k+WIDTH:
  - If Q[0]=1, add M to the upper WIDTH+1 bits of acc.
  - Then shift {acc,Q} right by 1 and increment bitCount.
  - After the WIDTH-th iteration (edge k+WIDTH), state->FIX.
- FIX (edge k+WIDTH+1): product <= negFlag ? -acc : acc, on 2*WIDTH bits with two's-complement wrap. Then done=1 for that one cycle and state->IDLE.
- Timing:
  - busy=1 from edge k through edge k+WIDTH+1, i.e. WIDTH+1 cycles.
  - done is high in the cycle after edge k+WIDTH+1, so total latency is WIDTH+2 edges from start.
  - done and busy are never high together.
- Handshake:
  - start while busy=1 is ignored; no queuing.
  - start held high continuously re-launches on each return to IDLE.
  - start in the cycle done=1 is accepted, giving back-to-back operation.
- Width rules:
  - The adder is WIDTH+1 bits; its carry feeds the acc MSB, so no overflow is possible in unsigned mode.
  - Signed magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - The most-negative squared result, 2^(2*WIDTH-2), fits in the 2*WIDTH-bit signed product.
- Zero operands: the operation still takes the full latency, and the result is 0 with no sign (negFlag ignored when acc=0, since -0=0).
- product changes only in FIX or on reset.

Decomposition:
- Shared package (mult_pkg):
  - State encoding constants IDLE=2'd0, RUN=2'd1, FIX=2'd2; unused encoding 2'd3 recovers to IDLE.
  - Function for magnitude/sign extraction.
  - WIDTH legality range constants.
- One sub-module: ripple_add_n, a parametrised (WIDTH+1)-bit adder built as a chain of the existing Full_Adder cell.
  - Instantiated once in the RUN datapath.
  - Negation in FIX uses a separate behavioural inverter-plus-one.

Test Plan (WIDTH=8):
- Unsigned 13*11, start pulse at edge k: busy 9 cycles; done pulse after edge k+9; product=16'd143; product holds after done.
- Unsigned 255*255: product=16'hFE01; no overflow artefact.
- Signed -3*5 (8'hFD, 8'h05): product=16'hFFF1. Signed -128*-128 (8'h80, 8'h80): product=16'h4000. Signed 0*-1: product=0.
- start re-pulsed with new operands at edges k+3 and k+5: ignored; result matches the original operands.
- reset asserted asynchronously mid-RUN (between edges k+4 and k+5): busy=0, done=0 and product=0 immediately; no done pulse follows.
- start high in the done cycle: second operation accepted; second done exactly 10 edges after the first; both products correct.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding,
// legal width range and operand magnitude/sign helpers.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } stateT;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // True when a width-bit operand is negative under two's-complement rules.
    function automatic logic operandNegative(input logic [31:0] value,
                                             input int width,
                                             input logic signedMode);
        return signedMode && value[width-1];
    endfunction

    // Absolute value of a width-bit operand; the low width bits of the result
    // are meaningful. The most-negative value maps to 2^(width-1).
    function automatic logic [31:0] operandMagnitude(input logic [31:0] value,
                                                     input int width,
                                                     input logic signedMode);
        if (operandNegative(value, width, signedMode)) begin
            return ~value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder cell used to build the ripple-carry adder.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic carryIn,
    output logic sum,
    output logic carryOut
);

    assign sum      = a ^ b ^ carryIn;
    assign carryOut = (a & b) | (carryIn & (a ^ b));

endmodule

// File: rtl/ripple_add_n.sv
// N-bit ripple-carry adder built from a chain of Full_Adder cells, carry-in 0.
module ripple_add_n #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         carryOut
);

    for (genvar gi = 0; gi < N; gi++) begin : gStage
        logic stageCarryIn;
        logic stageCarryOut;

        // Each stage owns its carry so the chain is not one self-dependent vector.
        if (gi == 0) begin : gFirst
            assign stageCarryIn = 1'b0;
        end else begin : gRest
            assign stageCarryIn = gStage[gi-1].stageCarryOut;
        end

        Full_Adder uFullAdder (
            .a        (a[gi]),
            .b        (b[gi]),
            .carryIn  (stageCarryIn),
            .sum      (sum[gi]),
            .carryOut (stageCarryOut)
        );
    end

    assign carryOut = gStage[N-1].stageCarryOut;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, signed operands
// handled as magnitudes with the sign reapplied in a final FIX cycle.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signedMode,
    input  logic [WIDTH-1:0]   inputM,
    input  logic [WIDTH-1:0]   inputQ,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : gWidthCheck
        $error("seq_shift_add_multiplier: WIDTH out of range");
    end

    stateT              stateReg, stateNext;
    logic [WIDTH-1:0]   mReg, mNext;
    logic [WIDTH-1:0]   qReg, qNext;
    logic [WIDTH:0]     accReg, accNext;
    logic [CW-1:0]      bitCountReg, bitCountNext;
    logic               negFlagReg, negFlagNext;
    logic [2*WIDTH-1:0] productReg, productNext;
    logic               doneReg, doneNext;

    logic [WIDTH:0]     adderSum;
    logic               unusedCarry;
    logic [WIDTH:0]     accSel;
    logic [2*WIDTH-1:0] magResult;

    // acc never exceeds 2^WIDTH-1 before an add, so the (WIDTH+1)-bit sum cannot carry out.
    ripple_add_n #(
        .N (WIDTH + 1)
    ) uAdder (
        .a        (accReg),
        .b        ({1'b0, mReg}),
        .sum      (adderSum),
        .carryOut (unusedCarry)
    );

    always_comb begin
        stateNext    = stateReg;
        mNext        = mReg;
        qNext        = qReg;
        accNext      = accReg;
        bitCountNext = bitCountReg;
        negFlagNext  = negFlagReg;
        productNext  = productReg;
        doneNext     = 1'b0;
        accSel       = qReg[0] ? adderSum : accReg;
        magResult    = {accReg[WIDTH-1:0], qReg};

        case (stateReg)
            IDLE: begin
                if (start) begin
                    mNext        = WIDTH'(operandMagnitude(32'(inputM), WIDTH, signedMode));
                    qNext        = WIDTH'(operandMagnitude(32'(inputQ), WIDTH, signedMode));
                    negFlagNext  = operandNegative(32'(inputM), WIDTH, signedMode)
                                 ^ operandNegative(32'(inputQ), WIDTH, signedMode);
                    accNext      = '0;
                    bitCountNext = '0;
                    stateNext    = RUN;
                end
            end
            RUN: begin
                {accNext, qNext} = {1'b0, accSel, qReg[WIDTH-1:1]};
                bitCountNext     = bitCountReg + CW'(1);
                if (bitCountReg == CW'(WIDTH - 1)) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                productNext = negFlagReg ? -magResult : magResult;
                doneNext    = 1'b1;
                stateNext   = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg    <= IDLE;
            mReg        <= '0;
            qReg        <= '0;
            accReg      <= '0;
            bitCountReg <= '0;
            negFlagReg  <= 1'b0;
            productReg  <= '0;
            doneReg     <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            mReg        <= mNext;
            qReg        <= qNext;
            accReg      <= accNext;
            bitCountReg <= bitCountNext;
            negFlagReg  <= negFlagNext;
            productReg  <= productNext;
            doneReg     <= doneNext;
        end
    end

    assign busy    = (stateReg != IDLE);
    assign done    = doneReg;
    assign product = productReg;

endmodule
